// File: rtl/bug_pkg.sv
// Shared bug geometry, FSM encoding and LFSR constants; the draw stage imports the same sizes.
// Pure declarations: no latency, no flow control.
package bug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

    localparam int DEF_SCREEN_W = 1024;
    localparam int DEF_SCREEN_H = 768;
    localparam int DEF_BUG_W    = 200;
    localparam int DEF_BUG_H    = 200;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic        dir;
        logic [11:0] pos;
    } axis_t;

    // Fold a 10-bit random value into [0, lim].
    function automatic logic [11:0] respawn_coord(input logic [9:0] r, input logic [11:0] lim);
        logic [11:0] rw;
        rw = {2'b00, r};
        return (rw > lim) ? (rw - lim) : rw;
    endfunction

    // One frame of bouncing motion; compare before subtracting so nothing wraps.
    function automatic axis_t step_axis(input logic [11:0] pos, input logic dir,
                                        input logic [11:0] lim, input logic [11:0] step);
        axis_t a;
        a.dir = dir;
        a.pos = pos;
        if (dir) begin
            if (({1'b0, pos} + {1'b0, step}) > {1'b0, lim}) begin
                a.pos = lim;
                a.dir = 1'b0;
            end else begin
                a.pos = pos + step;
            end
        end else begin
            if (pos < step) begin
                a.pos = '0;
                a.dir = 1'b1;
            end else begin
                a.pos = pos - step;
            end
        end
        return a;
    endfunction

endpackage

// File: rtl/bug_ctl_lfsr16.sv
// 16-bit Fibonacci LFSR, advancing every pclk; reloads the seed if it ever reads all-zero.
// Output is the register itself (0-cycle read), free-running with no stall input.
module lfsr16
    import bug_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
)(
    input  logic        pclk,
    input  logic        reset,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        if (lfsr_q == 16'h0000) begin
            lfsr_d = SEED;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/bug_ctl.sv
// Frame-synchronous bug mover: bounces, detects clicks on the sprite, scores, freezes, respawns.
// Position lands on x/y_bugpos 2 cycles after vblnk_in rises; no backpressure, outputs always valid.
module bug_ctl
    import bug_pkg::*;
#(
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int BUG_W      = DEF_BUG_W,
    parameter int BUG_H      = DEF_BUG_H,
    parameter int STEP       = 4,
    parameter int HIT_FRAMES = 30,
    parameter int X_START    = 100,
    parameter int Y_START    = 100
)(
    input  logic        pclk,
    input  logic        reset,
    input  logic        vblnk_in,
    input  logic        start,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    output logic [11:0] x_bugpos,
    output logic [11:0] y_bugpos,
    output logic        hit,
    output logic [7:0]  score,
    output logic [1:0]  state_dbg
);

    localparam logic [11:0] XMAX    = 12'(SCREEN_W - BUG_W);
    localparam logic [11:0] YMAX    = 12'(SCREEN_H - BUG_H);
    localparam logic [11:0] STEP_V  = 12'(STEP);
    localparam logic [11:0] X_RST   = 12'(X_START);
    localparam logic [11:0] Y_RST   = 12'(Y_START);
    localparam logic [7:0]  HIT_CNT = 8'(HIT_FRAMES);

    state_e      state_q, state_d;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [7:0]  score_q, score_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        hit_q, hit_d;
    logic        vblnk_q, left_q;
    logic [11:0] x_out_q, y_out_q;

    logic [15:0] lfsr;
    logic        frame_tick, click, in_bug;
    axis_t       ax, ay;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .pclk   (pclk),
        .reset  (reset),
        .lfsr_o (lfsr)
    );

    assign frame_tick = vblnk_in & ~vblnk_q;
    assign click      = mouse_left & ~left_q;

    // Extra bit keeps x+BUG_W from wrapping near the right edge.
    assign in_bug = (mouse_xpos >= x_q) && ({1'b0, mouse_xpos} < ({1'b0, x_q} + 13'(BUG_W))) &&
                    (mouse_ypos >= y_q) && ({1'b0, mouse_ypos} < ({1'b0, y_q} + 13'(BUG_H)));

    assign ax = step_axis(x_q, dir_x_q, XMAX, STEP_V);
    assign ay = step_axis(y_q, dir_y_q, YMAX, STEP_V);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        score_d = score_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_tick && start) begin
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                // A hit takes priority over a coincident frame move.
                if (click && in_bug) begin
                    hit_d   = 1'b1;
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    cnt_d   = HIT_CNT;
                    state_d = ST_FROZEN;
                end else if (frame_tick) begin
                    if (!start) begin
                        state_d = ST_IDLE;
                        x_d     = X_RST;
                        y_d     = Y_RST;
                        dir_x_d = 1'b1;
                        dir_y_d = 1'b1;
                    end else begin
                        x_d     = ax.pos;
                        dir_x_d = ax.dir;
                        y_d     = ay.pos;
                        dir_y_d = ay.dir;
                    end
                end
            end
            ST_FROZEN: begin
                if (frame_tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        cnt_d = '0;
                        if (start) begin
                            state_d = ST_MOVE;
                            x_d     = respawn_coord(lfsr[9:0], XMAX);
                            y_d     = respawn_coord(lfsr[15:6], YMAX);
                        end else begin
                            state_d = ST_IDLE;
                            x_d     = X_RST;
                            y_d     = Y_RST;
                            dir_x_d = 1'b1;
                            dir_y_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= X_RST;
            y_q     <= Y_RST;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
            score_q <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            vblnk_q <= 1'b0;
            left_q  <= 1'b0;
            x_out_q <= X_RST;
            y_out_q <= Y_RST;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            score_q <= score_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            vblnk_q <= vblnk_in;
            left_q  <= mouse_left;
            x_out_q <= x_q;
            y_out_q <= y_q;
        end
    end

    assign x_bugpos  = x_out_q;
    assign y_bugpos  = y_out_q;
    assign hit       = hit_q;
    assign score     = score_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bug_ctl.sv
// Directed bench for bug_ctl with a behavioural reference model and expectation queues.
module tb_bug_ctl;

    logic        pclk = 1'b0;
    logic        reset;
    logic        vblnk_in;
    logic        start;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic [11:0] x_bugpos;
    logic [11:0] y_bugpos;
    logic        hit;
    logic [7:0]  score;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [1:0]  st;
        logic [7:0]  sc;
    } exp_t;

    exp_t sb[$];
    bit   hq[$];

    // Reference model state
    int          m_x, m_y, m_state, m_score, m_cnt;
    bit          m_dx, m_dy;
    logic [15:0] lfsr_m;

    bug_ctl #(.HIT_FRAMES(3)) dut (
        .pclk       (pclk),
        .reset      (reset),
        .vblnk_in   (vblnk_in),
        .start      (start),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .mouse_left (mouse_left),
        .x_bugpos   (x_bugpos),
        .y_bugpos   (y_bugpos),
        .hit        (hit),
        .score      (score),
        .state_dbg  (state_dbg)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        if (reset) lfsr_m <= 16'hACE1;
        else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s mismatched", tag);
        end
    endtask

    task automatic model_reset_pos();
        m_x = 100; m_y = 100; m_dx = 1'b1; m_dy = 1'b1;
    endtask

    task automatic step(inout int pos, inout bit dir, input int lim);
        if (dir) begin
            if (pos + 4 > lim) begin pos = lim; dir = 1'b0; end
            else pos = pos + 4;
        end else begin
            if (pos < 4) begin pos = 0; dir = 1'b1; end
            else pos = pos - 4;
        end
    endtask

    task automatic model_tick();
        int r;
        case (m_state)
            0: if (start) m_state = 1;
            1: begin
                if (!start) begin
                    m_state = 0;
                    model_reset_pos();
                end else begin
                    step(m_x, m_dx, 824);
                    step(m_y, m_dy, 568);
                end
            end
            default: begin
                if (m_cnt == 1) begin
                    if (start) begin
                        m_state = 1;
                        r = int'(lfsr_m[9:0]);
                        m_x = (r > 824) ? r - 824 : r;
                        r = int'(lfsr_m[15:6]);
                        m_y = (r > 568) ? r - 568 : r;
                    end else begin
                        m_state = 0;
                        model_reset_pos();
                    end
                end
                m_cnt = m_cnt - 1;
            end
        endcase
    endtask

    task automatic push_exp();
        exp_t e;
        e.x = 12'(m_x); e.y = 12'(m_y); e.st = 2'(m_state); e.sc = 8'(m_score);
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, "_x"}, 32'(x_bugpos), 32'(e.x));
        chk({tag, "_y"}, 32'(y_bugpos), 32'(e.y));
        chk({tag, "_state"}, 32'(state_dbg), 32'(e.st));
        chk({tag, "_score"}, 32'(score), 32'(e.sc));
    endtask

    task automatic frame(input string tag, input bit early_chk);
        int px, py;
        @(negedge pclk);
        px = m_x; py = m_y;
        vblnk_in = 1'b1;
        model_tick();
        push_exp();
        @(negedge pclk);
        vblnk_in = 1'b0;
        if (early_chk) begin
            chk({tag, "_early_x"}, 32'(x_bugpos), 32'(px));
            chk({tag, "_early_y"}, 32'(y_bugpos), 32'(py));
        end
        @(negedge pclk);
        pop_chk(tag);
        @(negedge pclk);
    endtask

    task automatic click(input string tag, input int mx, input int my, input bit with_tick);
        bit exp_hit;
        @(negedge pclk);
        mouse_xpos = 12'(mx);
        mouse_ypos = 12'(my);
        mouse_left = 1'b1;
        exp_hit = (m_state == 1) && (mx >= m_x) && (mx < m_x + 200) && (my >= m_y) && (my < m_y + 200);
        if (with_tick) vblnk_in = 1'b1;
        if (exp_hit) begin
            m_score = (m_score == 255) ? 255 : m_score + 1;
            m_state = 2;
            m_cnt   = 3;
        end else if (with_tick) begin
            model_tick();
        end
        hq.push_back(exp_hit);
        push_exp();
        @(negedge pclk);
        mouse_left = 1'b0;
        vblnk_in   = 1'b0;
        chk({tag, "_hit"}, 32'(hit), 32'(hq.pop_front()));
        @(negedge pclk);
        chk({tag, "_hit_clear"}, 32'(hit), 32'd0);
        pop_chk(tag);
        @(negedge pclk);
    endtask

    initial begin
        reset = 1'b1; vblnk_in = 1'b0; start = 1'b0;
        mouse_xpos = '0; mouse_ypos = '0; mouse_left = 1'b0;
        model_reset_pos();
        m_state = 0; m_score = 0; m_cnt = 0;
        repeat (3) @(negedge pclk);
        reset = 1'b0;
        chk("rst_x", 32'(x_bugpos), 32'd100);
        chk("rst_y", 32'(y_bugpos), 32'd100);
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);

        for (int i = 0; i < 5; i++) frame("idle", 1'b0);

        start = 1'b1;
        frame("enter_move", 1'b1);
        for (int i = 0; i < 3; i++) frame("move", 1'b1);
        chk("move3_x", 32'(x_bugpos), 32'd112);
        chk("move3_y", 32'(y_bugpos), 32'd112);

        for (int i = 0; i < 47; i++) frame("to300", 1'b0);
        chk("at300_x", 32'(x_bugpos), 32'd300);

        click("miss_xexcl", 500, 300, 1'b0);
        click("miss_left", 299, 300, 1'b0);
        click("miss_yexcl", 300, 500, 1'b0);
        click("hit1", 300, 499, 1'b0);
        chk("hit1_state", 32'(state_dbg), 32'd2);
        chk("hit1_score", 32'(score), 32'd1);
        click("frozen_ignored", 310, 310, 1'b0);

        frame("frozen1", 1'b0);
        frame("frozen2", 1'b0);
        frame("respawn", 1'b0);
        chk("respawn_state", 32'(state_dbg), 32'd1);
        chk("respawn_x_range", 32'(x_bugpos <= 12'd824), 32'd1);
        chk("respawn_y_range", 32'(y_bugpos <= 12'd568), 32'd1);

        // Long run so the bug bounces off all four edges from a non-aligned start.
        for (int i = 0; i < 300; i++) frame("bounce", 1'b0);

        click("hit_with_tick", m_x + 10, m_y + 10, 1'b1);
        for (int i = 0; i < 3; i++) frame("refreeze", 1'b0);

        start = 1'b0;
        frame("move_stop", 1'b0);
        chk("move_stop_state", 32'(state_dbg), 32'd0);
        start = 1'b1;
        frame("restart", 1'b0);

        while (m_score < 255) begin
            click("sat_loop", m_x + 1, m_y + 1, 1'b0);
            for (int i = 0; i < 3; i++) frame("sat_frz", 1'b0);
        end
        chk("score_255", 32'(score), 32'd255);
        click("sat_hit", m_x + 199, m_y + 199, 1'b0);
        chk("score_sat", 32'(score), 32'd255);

        start = 1'b0;
        for (int i = 0; i < 3; i++) frame("frz_to_idle", 1'b0);
        chk("frz_idle_state", 32'(state_dbg), 32'd0);
        chk("frz_idle_x", 32'(x_bugpos), 32'd100);

        start = 1'b1;
        frame("rearm", 1'b0);
        click("pre_reset_hit", m_x + 5, m_y + 5, 1'b0);
        @(negedge pclk);
        reset = 1'b1;
        @(negedge pclk);
        chk("midrst_state", 32'(state_dbg), 32'd0);
        chk("midrst_x", 32'(x_bugpos), 32'd100);
        chk("midrst_y", 32'(y_bugpos), 32'd100);
        chk("midrst_score", 32'(score), 32'd0);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
